// File: rtl/tof_pkg.sv
// rtl/tof_pkg.sv - shared constants, index type and write-FSM state encoding for the ToF data path.
package tof_pkg;

  localparam int N_SENSORS = 8;
  localparam int IDX_W     = 3;
  localparam int ZONES     = 64;
  localparam int ZONE_W    = 6;
  localparam int DATA_W    = 16;
  localparam int WORD_W    = 22;
  localparam int CNT_W     = $clog2(ZONES + 1);

  typedef logic [IDX_W-1:0] tof_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WRITE
  } wr_state_e;

endpackage

// File: rtl/tof_idx_arbiter.sv
// rtl/tof_idx_arbiter.sv - picks the next sensor to service from the pending vector.
// MEM_WRITE_RR_EN: round-robin starting after last_idx_i; otherwise lowest pending index wins.
import tof_pkg::*;

module tof_idx_arbiter (
  input  logic [N_SENSORS-1:0] pending_i,
  input  logic [IDX_W-1:0]     last_idx_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  tof_idx_t cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
`ifdef MEM_WRITE_RR_EN
    for (int off = 1; off <= N_SENSORS; off++) begin
      cand = tof_idx_t'((int'(last_idx_i) + off) % N_SENSORS);
      if (!valid_o && pending_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
`else
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      cand = tof_idx_t'(i);
      if (pending_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/mem_write_fsm.sv
// rtl/mem_write_fsm.sv - ToF write controller: data-ready edge capture, sensor select, BRAM write strobes.
// MEM_WRITE_RR_EN selects round-robin sensor arbitration (default fixed priority).
import tof_pkg::*;

module mem_write_fsm (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] ToF_dr,
  output logic                 wea,
  output logic [IDX_W-1:0]     ToF_Index,
  output logic                 all_data_written
);

  logic [N_SENSORS-1:0] dr_q;
  logic [N_SENSORS-1:0] pending_q;
  logic [N_SENSORS-1:0] pending_d;
  logic [N_SENSORS-1:0] rise;
  logic [N_SENSORS-1:0] clr;
  logic [CNT_W-1:0]     cnt_q [N_SENSORS];
  logic [CNT_W-1:0]     cnt_d [N_SENSORS];
  wr_state_e            state_q;
  tof_idx_t             idx_q;
  tof_idx_t             arb_idx;
  logic                 arb_valid;
  logic                 wea_q;
  logic                 adw_q;
  logic                 all_full;
  logic                 frame_done;

  tof_idx_arbiter u_arb (
    .pending_i  (pending_q),
    .last_idx_i (idx_q),
    .idx_o      (arb_idx),
    .valid_o    (arb_valid)
  );

  always_comb begin
    rise = ToF_dr & ~dr_q;
    clr  = '0;
    if (state_q == WRITE) clr[idx_q] = 1'b1;
    // A rise landing in the same cycle as the clear keeps the bit set.
    pending_d = (pending_q & ~clr) | rise;

    cnt_d = cnt_q;
    if (state_q == WRITE && cnt_q[idx_q] != CNT_W'(ZONES))
      cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;

    all_full = 1'b1;
    for (int i = 0; i < N_SENSORS; i++)
      if (cnt_d[i] != CNT_W'(ZONES)) all_full = 1'b0;

    // Completion is flagged on the edge that closes the final write, so the
    // pulse and the cleared counters appear in the cycle right after wea.
    frame_done = (state_q == WRITE) && all_full;
    if (frame_done)
      for (int i = 0; i < N_SENSORS; i++) cnt_d[i] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_q      <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      wea_q     <= 1'b0;
      adw_q     <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) cnt_q[i] <= '0;
    end else begin
      dr_q      <= ToF_dr;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      adw_q     <= frame_done;
      wea_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            idx_q   <= arb_idx;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          wea_q   <= 1'b1;
          state_q <= WRITE;
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wea              = wea_q;
  assign ToF_Index        = idx_q;
  assign all_data_written = adw_q;

endmodule

// File: tb/tb_mem_write_fsm.sv
// tb/tb_mem_write_fsm.sv - self-checking bench for mem_write_fsm against a timestamp-based reference model.
module tb_mem_write_fsm;
  import tof_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ToF_dr;
  logic       wea;
  logic [2:0] ToF_Index;
  logic       all_data_written;

  always #5 clk = ~clk;

  mem_write_fsm dut (
    .clk              (clk),
    .reset            (reset),
    .ToF_dr           (ToF_dr),
    .wea              (wea),
    .ToF_Index        (ToF_Index),
    .all_data_written (all_data_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a service chosen at edge s shows its index after s,
  // strobes wea after s+1, and completes (clear, count) at edge s+2.
  int         cyc = 0;
  bit         svc_active = 0;
  int         svc_start = 0;
  int         last_idx = 0;
  int         adw_cyc = -1;
  int         m_cnt [N_SENSORS];
  bit         m_pend [N_SENSORS];
  logic [7:0] m_prev = '0;
  int         m_writes = 0;
  int         sel;
  bit         full;

  function automatic int pick_next();
`ifdef MEM_WRITE_RR_EN
    for (int off = 1; off <= N_SENSORS; off++)
      if (m_pend[(last_idx + off) % N_SENSORS]) return (last_idx + off) % N_SENSORS;
`else
    for (int i = 0; i < N_SENSORS; i++)
      if (m_pend[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      svc_active = 0;
      last_idx   = 0;
      adw_cyc    = -1;
      m_prev     = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
        m_cnt[i]  = 0;
        m_pend[i] = 0;
      end
    end else begin
      cyc++;
      if (svc_active && cyc == svc_start + 2) begin
        m_pend[last_idx] = 0;
        m_writes++;
        if (m_cnt[last_idx] < ZONES) m_cnt[last_idx]++;
        full = 1;
        for (int i = 0; i < N_SENSORS; i++) if (m_cnt[i] != ZONES) full = 0;
        if (full) begin
          adw_cyc = cyc;
          for (int i = 0; i < N_SENSORS; i++) m_cnt[i] = 0;
        end
        svc_active = 0;
      end else if (!svc_active) begin
        sel = pick_next();
        if (sel >= 0) begin
          svc_active = 1;
          svc_start  = cyc;
          last_idx   = sel;
        end
      end
      for (int i = 0; i < N_SENSORS; i++)
        if (ToF_dr[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev = ToF_dr;
    end
  end

  int wea_cnt = 0;
  int adw_cnt = 0;
  int ncyc = 0;
  int last_wea_n = 0;
  int adw_gap = 0;
  int wea_at_adw = 0;
  int wea_log[$];
  int wea_t[$];

  always @(negedge clk) begin
    if (!reset) begin
      check("wea", wea, (svc_active && cyc == svc_start + 1));
      check("idx", ToF_Index, last_idx);
      check("adw", all_data_written, (cyc == adw_cyc));
      ncyc++;
      if (wea) begin
        wea_cnt++;
        wea_log.push_back(ToF_Index);
        wea_t.push_back(ncyc);
        last_wea_n = ncyc;
      end
      if (all_data_written) begin
        adw_cnt++;
        adw_gap    = ncyc - last_wea_n;
        wea_at_adw = wea_cnt;
      end
    end
  end

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    #1;
    ToF_dr = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(ToF_dr);
  endtask

  int w0, a0, mw0, n0, n5;

  initial begin
    reset  = 1'b1;
    ToF_dr = '0;
    repeat (2) @(negedge clk);
    check("rst_wea", wea, 0);
    check("rst_idx", ToF_Index, 0);
    check("rst_adw", all_data_written, 0);
    #1 reset = 1'b0;

    // Single event; the level stays high and must not retrigger.
    w0 = wea_cnt;
    wea_log.delete();
    drive(8'h04);
    idle(20);
    check("single_count", wea_cnt - w0, 1);
    check("single_idx", wea_log[0], 2);
    drive(8'h00);
    idle(3);

    // Simultaneous rise on sensors 0 and 7.
    w0 = wea_cnt;
    wea_log.delete();
    wea_t.delete();
    drive(8'h81);
    idle(12);
    check("sim_count", wea_cnt - w0, 2);
`ifdef MEM_WRITE_RR_EN
    check("sim_first", wea_log[0], 7);
    check("sim_second", wea_log[1], 0);
`else
    check("sim_first", wea_log[0], 0);
    check("sim_second", wea_log[1], 7);
`endif
    check("sim_gap", wea_t[1] - wea_t[0], 3);
    drive(8'h00);
    idle(3);

    // Reset while in SELECT: outputs clear at once, the word is dropped.
    drive(8'h08);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_idx", ToF_Index, 3);
    reset  = 1'b1;
    ToF_dr = '0;
    #1;
    check("async_wea", wea, 0);
    check("async_idx", ToF_Index, 0);
    check("async_adw", all_data_written, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    w0 = wea_cnt;
    idle(10);
    check("abort_no_write", wea_cnt - w0, 0);

    // Overrun on sensor 5, then a frame with sensor 0 sending 70 words.
    w0 = wea_cnt;
    adw_cnt = 0;
    wea_log.delete();
    drive(8'h20);
    drive(8'h00);
    drive(8'h20);
    drive(8'h00);
    idle(6);
    check("overrun_writes", wea_cnt - w0, 1);
    for (int r = 0; r < 70; r++) begin
      logic [7:0] m;
      m = 8'h00;
      if (r < 64) m = m | 8'hDF;
      if (r < 63) m = m | 8'h20;
      m = m | 8'h01;
      drive(m);
      drive(8'h00);
      idle(26);
    end
    check("frame_writes", wea_cnt - w0, 518);
    check("frame_adw_count", adw_cnt, 1);
    check("frame_adw_at", wea_at_adw - w0, 512);
    check("frame_adw_gap", adw_gap, 1);
    n0 = 0;
    n5 = 0;
    foreach (wea_log[i]) begin
      if (wea_log[i] == 0) n0++;
      if (wea_log[i] == 5) n5++;
    end
    check("sat_s0_writes", n0, 70);
    check("overrun_s5_writes", n5, 64);

    // Counters restarted: another full frame yields exactly one more pulse.
    a0 = adw_cnt;
    for (int r = 0; r < 64; r++) begin
      drive(8'hFF);
      drive(8'h00);
      idle(26);
    end
    check("frame2_adw", adw_cnt - a0, 1);

    // Random toggling compared cycle by cycle against the model.
    w0  = wea_cnt;
    mw0 = m_writes;
    for (int c = 0; c < 1500; c++)
      drive(ToF_dr ^ 8'($urandom & $urandom & $urandom));
    drive(8'h00);
    idle(30);
    check("rand_writes", wea_cnt - w0, m_writes - mw0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
